// File: rtl/moxie_ifetch_wb.sv
// Wishbone instruction-fetch master with a prefetch FIFO, flushed and redirected on branch.
// Define MOXIE_IFETCH_ERR_EN to add wb_err_i handling with a sticky fault_o / fault_pc_o.
module moxie_ifetch_wb #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    DEPTH        = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 32'h00001000
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      branch_flag_i,
  input  logic [ADDR_WIDTH-1:0]     branch_target_i,
  output logic [DATA_WIDTH-1:0]     word_o,
  output logic [ADDR_WIDTH-1:0]     word_pc_o,
  output logic                      word_valid_o,
  input  logic                      word_ready_i,
  output logic [ADDR_WIDTH-1:0]     wb_adr_o,
  output logic                      wb_cyc_o,
  output logic                      wb_stb_o,
  output logic                      wb_we_o,
  output logic [DATA_WIDTH/8-1:0]   wb_sel_o,
  input  logic [DATA_WIDTH-1:0]     wb_dat_i,
  input  logic                      wb_ack_i
`ifdef MOXIE_IFETCH_ERR_EN
  ,
  input  logic                      wb_err_i,
  output logic                      fault_o,
  output logic [ADDR_WIDTH-1:0]     fault_pc_o
`endif
);

  localparam int STEP = DATA_WIDTH / 8;
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW   = $clog2(DEPTH + 1);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(STEP - 1);

  // IDLE: bus quiet | REQ: fetch at ptr | DRAIN: waiting out a stale ack after a branch
  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d, adr_q, adr_d, target;
  logic [CW-1:0]           count_q, count_after_pop;
  logic [PW-1:0]           wr_q, rd_q;
  logic [DATA_WIDTH-1:0]   data_mem [DEPTH];
  logic [ADDR_WIDTH-1:0]   pc_mem   [DEPTH];
  logic                    push, pop, err, halted;

`ifdef MOXIE_IFETCH_ERR_EN
  logic                    fault_q;
  logic [ADDR_WIDTH-1:0]   fault_pc_q;

  assign err        = wb_err_i;
  assign halted     = fault_q;
  assign fault_o    = fault_q;
  assign fault_pc_o = fault_pc_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
    end else if (branch_flag_i) begin
      fault_q    <= 1'b0;
    end else if (state_q == REQ && err && !wb_ack_i) begin
      fault_q    <= 1'b1;
      fault_pc_q <= adr_q;
    end
  end
`else
  assign err    = 1'b0;
  assign halted = 1'b0;
`endif

  assign target          = branch_target_i & ALIGN_MASK;
  assign word_valid_o    = (count_q != '0);
  assign pop             = word_valid_o & word_ready_i & ~branch_flag_i;
  assign count_after_pop = count_q - CW'(pop);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (branch_flag_i) begin
          ptr_d   = target;
          state_d = REQ;
        end else if (!halted && count_after_pop < CW'(DEPTH)) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (branch_flag_i) begin
          ptr_d   = target;
          state_d = (wb_ack_i || err) ? REQ : DRAIN;
        end else if (wb_ack_i) begin
          push    = 1'b1;
          ptr_d   = ptr_q + ADDR_WIDTH'(STEP);
          state_d = ((count_after_pop + CW'(1)) < CW'(DEPTH)) ? REQ : IDLE;
        end else if (err) begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (branch_flag_i) ptr_d = target;
        if (wb_ack_i || err) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
    // The bus address follows the pointer only when a new request starts; DRAIN keeps the stale one.
    adr_d = (state_d == REQ) ? ptr_d : adr_q;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      ptr_q   <= RESET_VECTOR;
      adr_q   <= RESET_VECTOR;
      count_q <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      adr_q   <= adr_d;
      if (branch_flag_i) begin
        count_q <= '0;
        wr_q    <= '0;
        rd_q    <= '0;
      end else begin
        count_q <= count_q + CW'(push) - CW'(pop);
        if (push) wr_q <= wr_q + PW'(1);
        if (pop)  rd_q <= rd_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i] <= '0;
        pc_mem[i]   <= '0;
      end
    end else if (push) begin
      data_mem[wr_q] <= wb_dat_i;
      pc_mem[wr_q]   <= adr_q;
    end
  end

  assign word_o    = data_mem[rd_q];
  assign word_pc_o = pc_mem[rd_q];
  assign wb_adr_o  = adr_q;
  assign wb_stb_o  = (state_q != IDLE);
  assign wb_cyc_o  = wb_stb_o;
  assign wb_we_o   = 1'b0;
  assign wb_sel_o  = '1;

endmodule
